pipe_stage_reg: RTL

//  Parametrised multi-stage pipeline register with per-stage valid bits, stall (hold) and flush (bubble insert).
//  It generalises the single-stage enable register: configurable width and depth, valid tracking, squash to NOP, and occupancy.
//  It sits between MIPS32 pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and is driven by the hazard unit.

---
 rtl/pipe_stage_reg_pkg.sv | 13 +
 rtl/pipe_sat_counter.sv | 32 +++
 rtl/pipe_stage_reg.sv | 105 ++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and helpers for the multi-stage pipeline register.
// Holds the MIPS NOP encoding, default perf counter width and occupancy width.
package pipe_stage_reg_pkg;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  localparam int unsigned PERF_CNT_W = 16;

  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Holds at all-ones instead of wrapping.
module pipe_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// DEPTH-stage pipeline register with valid tracking, stall, flush and occupancy.
// Define PIPE_PERF_CNT_EN to add saturating stall/flush cycle counters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       DEPTH     = 1,
  parameter logic [WIDTH-1:0]  NOP_VALUE = WIDTH'(MIPS_NOP),
  parameter int unsigned       CNT_W     = PERF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      valid_in,
  input  logic [WIDTH-1:0]          d,
  output logic                      valid_out,
  output logic [WIDTH-1:0]          q,
  output logic [occ_w(DEPTH)-1:0]   occ
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
`endif
);

  localparam int unsigned OCC_W = occ_w(DEPTH);

  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_stage_reg: DEPTH must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipe_stage_reg: CNT_W must be >= 1");
  end

  logic [WIDTH-1:0] data_w [DEPTH];
  logic [DEPTH-1:0] vld_w;

  // Stage 0 sits nearest the input; an invalid stage always carries NOP_VALUE.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             vld_q;
    logic             vld_d;

    if (k == 0) begin : g_head
      always_comb begin
        vld_d  = valid_in;
        data_d = valid_in ? d : NOP_VALUE;
      end
    end else begin : g_body
      always_comb begin
        vld_d  = vld_w[k-1];
        data_d = data_w[k-1];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        data_q <= NOP_VALUE;
        vld_q  <= 1'b0;
      end else if (flush) begin
        data_q <= NOP_VALUE;
        vld_q  <= 1'b0;
      end else if (!stall) begin
        data_q <= data_d;
        vld_q  <= vld_d;
      end
    end

    assign data_w[k] = data_q;
    assign vld_w[k]  = vld_q;
  end

  assign valid_out = vld_w[DEPTH-1];
  assign q         = data_w[DEPTH-1];
  assign occ       = OCC_W'($countones(vld_w));

`ifdef PIPE_PERF_CNT_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = stall & ~flush;
  assign flush_inc = flush;

  pipe_sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .q   (stall_cnt)
  );

  pipe_sat_counter #(
    .WIDTH (CNT_W)
  ) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .q   (flush_cnt)
  );
`endif

endmodule
